// File: rtl/btn_ctrl_pkg.sv
// Shared constants and elaboration-time helpers for the push-button front-end.
package btn_ctrl_pkg;

  localparam int DEF_NUM_BTN   = 4;
  localparam int DEF_CLK_HZ    = 100_000_000;
  localparam int DEF_SAMPLE_HZ = 5_000;
  localparam int DEF_DEPTH     = 16;

  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Prescaler divide ratio between the system clock and the filter sample rate.
  function automatic int div_f(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Event-id width; never narrower than one bit.
  function automatic int id_w_f(input int num_btn);
    return (clog2_f(num_btn) < 1) ? 1 : clog2_f(num_btn);
  endfunction

  localparam int DEF_ID_W = id_w_f(DEF_NUM_BTN);

endpackage

// File: rtl/btn_filter.sv
// One button: 2-flop synchroniser, sampled history and hysteresis level with
// a press (rising-level) strobe valid on the tick edge that raises the level.
module btn_filter
  import btn_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] hist_q;
  logic [DEPTH-1:0] hist_next;
  logic             level_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (tick) begin
        hist_q <= hist_next;
        level  <= level_next;
      end
    end
  end

  // The level only moves on a unanimous history, so isolated glitches are absorbed.
  always_comb begin
    hist_next  = {sync_q[1], hist_q[DEPTH-1:1]};
    level_next = level;
    if (&hist_next) begin
      level_next = 1'b1;
    end else if (~|hist_next) begin
      level_next = 1'b0;
    end
    rise = tick & level_next & ~level;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Button front-end: shared sample prescaler, per-button filters, pending press
// register and a round-robin arbiter presenting one event at a time.
module button_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int NUM_BTN   = DEF_NUM_BTN,
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int SAMPLE_HZ = DEF_SAMPLE_HZ,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BTN-1:0]          btn_raw,
  output logic                        sample_tick,
  output logic [NUM_BTN-1:0]          btn_level,
  output logic                        evt_valid,
  output logic [id_w_f(NUM_BTN)-1:0]  evt_id,
  input  logic                        evt_ready
);

  localparam int DIV   = div_f(CLK_HZ, SAMPLE_HZ);
  localparam int CNT_W = clog2_f(DIV);
  localparam int ID_W  = id_w_f(NUM_BTN);

  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_wrap;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] pending_q;
  logic [NUM_BTN-1:0] pending_next;
  logic [NUM_BTN-1:0] grant_mask;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant;
  logic               found;
  logic               load;

  assign cnt_wrap = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sample_tick <= 1'b0;
    end else begin
      cnt_q       <= cnt_wrap ? '0 : cnt_q + 1'b1;
      sample_tick <= cnt_wrap;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_filt
    btn_filter #(.DEPTH(DEPTH)) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (sample_tick),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .rise  (rise_vec[i])
    );
  end

  // Handshake: an event transfers on a cycle where evt_valid & evt_ready; while
  // valid is high and ready low, evt_valid/evt_id stay frozen. A transfer and
  // the next load share the same edge, so back-to-back events have no bubble.
  assign load = !evt_valid || evt_ready;

  // Scan downwards so the lowest rotation distance from rr_ptr+1 wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_BTN);
      if (pending_q[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // A rise landing on the bit being granted wins, keeping that bit pending.
  always_comb begin
    grant_mask = '0;
    if (load && found) begin
      grant_mask = NUM_BTN'(1) << grant;
    end
    pending_next = (pending_q & ~grant_mask) | rise_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_ptr_q  <= ID_W'(NUM_BTN - 1);
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      pending_q <= pending_next;
      if (load) begin
        if (found) begin
          evt_valid <= 1'b1;
          evt_id    <= grant;
          rr_ptr_q  <= grant;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with NUM_BTN=4, DIV=4, DEPTH=4.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       sample_tick;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] raw;
    int         clks;
    logic [3:0] exp_level;
    int         n_ev;
    logic [1:0] id0;
    logic [1:0] id1;
  } row_t;

  row_t rows[6];

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN   (4),
    .CLK_HZ    (20_000),
    .SAMPLE_HZ (5_000),
    .DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .sample_tick (sample_tick),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (evt_valid !== 1'b1 && c < 60) begin
      step(1);
      c++;
    end
    if (evt_valid !== 1'b1) check(name, 0, 1);
  endtask

  // Scoreboard: every accepted event is matched against the expected queue.
  always @(posedge clk) begin
    logic [1:0] e;
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got id %0d expected none (t=%0t)", evt_id, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_id", {30'd0, evt_id}, {30'd0, e});
      end
    end
  end

  initial begin
    int acc0;
    int n_edges;
    int qual;
    logic prev_tick;
    logic done;
    logic drop;
    logic stable;

    rows[0] = '{raw: 4'b0001, clks: 30, exp_level: 4'b0001, n_ev: 1, id0: 2'd0, id1: 2'd0};
    rows[1] = '{raw: 4'b0000, clks: 30, exp_level: 4'b0000, n_ev: 0, id0: 2'd0, id1: 2'd0};
    rows[2] = '{raw: 4'b0101, clks: 30, exp_level: 4'b0101, n_ev: 2, id0: 2'd2, id1: 2'd0};
    rows[3] = '{raw: 4'b0100, clks: 30, exp_level: 4'b0100, n_ev: 0, id0: 2'd0, id1: 2'd0};
    rows[4] = '{raw: 4'b1100, clks: 30, exp_level: 4'b1100, n_ev: 1, id0: 2'd3, id1: 2'd0};
    rows[5] = '{raw: 4'b0000, clks: 30, exp_level: 4'b0000, n_ev: 0, id0: 2'd0, id1: 2'd0};

    // Reset and prescaler cadence
    rst_n     = 1'b0;
    btn_raw   = 4'b0000;
    evt_ready = 1'b1;
    step(3);
    check("rst_tick", {31'd0, sample_tick}, 0);
    check("rst_level", {28'd0, btn_level}, 0);
    check("rst_valid", {31'd0, evt_valid}, 0);
    check("rst_id", {30'd0, evt_id}, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("tick_cadence", {31'd0, sample_tick}, (k % 4 == 0) ? 1 : 0);
    end

    // Table of press/release phases
    for (int r = 0; r < 6; r++) begin
      btn_raw = rows[r].raw;
      if (rows[r].n_ev > 0) exp_q.push_back(rows[r].id0);
      if (rows[r].n_ev > 1) exp_q.push_back(rows[r].id1);
      step(rows[r].clks);
      check("row_level", {28'd0, btn_level}, {28'd0, rows[r].exp_level});
      check("row_events_done", exp_q.size(), 0);
    end

    // Press latency on button 2, then release with no event
    exp_q.push_back(2'd2);
    btn_raw[2] = 1'b1;
    prev_tick  = sample_tick;
    n_edges    = 0;
    qual       = 0;
    done       = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step(1);
      n_edges++;
      if (prev_tick && n_edges >= 3) begin
        qual++;
        if (qual == 3) check("press_level_early", {31'd0, btn_level[2]}, 0);
        if (qual == 4) begin
          check("press_level_rise", {31'd0, btn_level[2]}, 1);
          check("press_valid_lag", {31'd0, evt_valid}, 0);
          done = 1'b1;
        end
      end
      prev_tick = sample_tick;
    end
    if (!done) check("press_timeout", 0, 1);
    step(1);
    check("press_evt", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd2});
    step(1);
    check("press_one_clk", {31'd0, evt_valid}, 0);
    acc0 = n_acc;
    btn_raw[2] = 1'b0;
    step(30);
    check("release_level", {31'd0, btn_level[2]}, 0);
    check("release_no_event", n_acc, acc0);

    // Bounce on button 1, then a single-sample glitch while held
    exp_q.push_back(2'd1);
    for (int i = 0; i < 60; i++) begin
      btn_raw[1] = ((i / 3) % 2) == 1;
      step(1);
    end
    btn_raw[1] = 1'b1;
    step(30);
    check("bounce_level", {28'd0, btn_level}, 4'b0010);
    check("bounce_one_event", exp_q.size(), 0);
    acc0 = n_acc;
    drop = 1'b0;
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (btn_level[1] !== 1'b1) drop = 1'b1;
    end
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (btn_level[1] !== 1'b1) drop = 1'b1;
    end
    check("glitch_level_held", {31'd0, drop}, 0);
    check("glitch_no_event", n_acc, acc0);
    btn_raw[1] = 1'b0;
    step(30);

    // Round-robin with a stall, starting from a fresh reset
    evt_ready = 1'b0;
    rst_n     = 1'b0;
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    btn_raw = 4'b1011;
    wait_valid("rr_valid_timeout");
    check("rr_first", {30'd0, evt_id}, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) stable = 1'b0;
    end
    check("rr_stall_stable", {31'd0, stable}, 1);
    evt_ready = 1'b1;
    step(1);
    check("rr_second", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd1});
    step(1);
    check("rr_third", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd3});
    step(1);
    check("rr_drained", {31'd0, evt_valid}, 0);
    btn_raw = 4'b0000;
    step(30);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    btn_raw = 4'b1001;
    step(30);
    check("rr_wrap_done", exp_q.size(), 0);
    btn_raw = 4'b0000;
    step(30);

    // Coalesce and re-press of button 2 while its event is stalled
    evt_ready = 1'b0;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    for (int i = 0; i < 3; i++) begin
      btn_raw = 4'b0100;
      step(30);
      btn_raw = 4'b0000;
      step(30);
    end
    check("coal_stalled", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd2});
    acc0 = n_acc;
    evt_ready = 1'b1;
    step(6);
    check("coal_two_events", n_acc - acc0, 2);
    check("coal_queue_empty", exp_q.size(), 0);

    // Reset while an event is presented and two more are pending
    evt_ready = 1'b0;
    btn_raw   = 4'b1011;
    wait_valid("midrst_valid_timeout");
    step(3);
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    step(1);
    check("midrst_valid", {31'd0, evt_valid}, 0);
    check("midrst_id", {30'd0, evt_id}, 0);
    check("midrst_level", {28'd0, btn_level}, 0);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    acc0      = n_acc;
    step(40);
    check("midrst_no_stale", n_acc, acc0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
